// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// R-type funct codes and the ALU operation class.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // 2'b11 is treated like ALUOP_FUNCT by the decoder.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

endpackage

// File: rtl/aludec.sv
// Combinational ALU decoder: maps the FSM's ALU operation class and the
// R-type funct field onto the 3-bit ALU control code.
module aludec
  import mips_ctrl_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [2:0]  alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      default: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-FSM control unit for a multicycle MIPS datapath; all outputs except
// pcen decode from the registered state, pcen also folds in the ALU zero flag.
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        pcen,
  output logic        memwrite,
  output logic        irwrite,
  output logic        regwrite,
  output logic        iord,
  output logic        alusrca,
  output logic        regdst,
  output logic        memtoreg,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic [2:0]  alucontrol,
  output logic [3:0]  state
);

  state_t     state_q;
  state_t     state_n;
  aluop_t     aluop;
  logic       pcwrite;
  logic       branch;
  logic       state_valid;
  logic [2:0] dec_alucontrol;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n     = FETCH;
    state_valid = 1'b1;
    pcwrite     = 1'b0;
    branch      = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regwrite    = 1'b0;
    iord        = 1'b0;
    alusrca     = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;
    aluop       = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        state_n = DECODE;
        irwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          LW, SW:  state_n = MEMADR;
          RTYPE:   state_n = EXECUTE;
          BEQ:     state_n = BRANCH;
          ADDI:    state_n = ADDIEXEC;
          J:       state_n = JUMP;
          default: state_n = FETCH;
        endcase
      end
      MEMADR: begin
        state_n = (op == LW) ? MEMRD : MEMWR;
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        state_n = MEMWB;
        iord    = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        state_n = ALUWB;
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEXEC: begin
        state_n = ADDIWB;
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: regwrite = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      // Encodings 12-15: recover to FETCH with every output forced low.
      default: state_valid = 1'b0;
    endcase
  end

  aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (dec_alucontrol)
  );

  assign alucontrol = state_valid ? dec_alucontrol : 3'b000;
  assign pcen       = pcwrite | (branch & zero);
  assign state      = state_q;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters SHALL be none; all encodings SHALL be fixed constants.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  6  instr[31:26] from the instruction register.
REQ-005 funct  input  6  instr[5:0] from the instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 pcen  output  1  PC register write enable.
REQ-008 memwrite  output  1  data memory write strobe.
REQ-009 irwrite  output  1  instruction register load.
REQ-010 regwrite  output  1  register file write enable.
REQ-011 iord, alusrca, regdst, memtoreg  output  1 each  datapath mux selects.
REQ-012 alusrcb  output  2  ALU B select: 00 reg B, 01 const 4, 10 signimm, 11 signimm<<2.
REQ-013 pcsrc  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-014 alucontrol  output  3  ALU operation code.
REQ-015 state  output  4  current FSM state, for debug and bench checks.

Function
REQ-016 The block SHALL be a Moore FSM; every output except pcen SHALL decode from the registered state only.
REQ-017 States and encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
REQ-018 Transitions: FETCH->DECODE always; DECODE by op: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BRANCH, 001000->ADDIEXEC, 000010->JUMP, any other->FETCH.
REQ-019 MEMADR->MEMRD if op=100011, else MEMWR; MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEXEC->ADDIWB; MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP->FETCH.
REQ-020 Unused encodings 12-15 SHALL go to FETCH on the next edge with all outputs 0.
REQ-021 FETCH outputs: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
REQ-022 DECODE: alusrcb=11, aluop=00. MEMADR and ADDIEXEC: alusrca=1, alusrcb=10, aluop=00.
REQ-023 MEMRD: iord=1. MEMWR: iord=1, memwrite=1. MEMWB: memtoreg=1, regwrite=1.
REQ-024 EXECUTE: alusrca=1, alusrcb=00, aluop=10. ALUWB: regdst=1, regwrite=1. ADDIWB: regwrite=1.
REQ-025 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. JUMP: pcsrc=10, pcwrite=1.
REQ-026 Any signal not listed for a state SHALL be 0 in that state.
REQ-027 pcen SHALL equal pcwrite OR (branch AND zero), combinationally from zero.
REQ-028 alucontrol SHALL be: aluop 00->010; 01->110; 10 or 11 by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010.
REQ-029 Cycles per instruction SHALL be lw 5, sw 4, R-type 4, addi 4, beq 3, j 3; illegal op 2 with no register or memory write.
REQ-030 op and funct SHALL be sampled only in DECODE, MEMADR and EXECUTE; changes elsewhere SHALL have no effect.

Reset
REQ-031 Reset high at a rising edge SHALL force state=FETCH regardless of current state, including mid-instruction (e.g. MEMWR).
REQ-032 While reset is high, all outputs SHALL hold the FETCH decode after the first edge; memwrite and regwrite SHALL never be 1 during reset.
REQ-033 Before the first edge with reset high, state SHALL be undefined; the bench SHALL hold reset for at least 2 edges.

Structure
REQ-034 Package mips_ctrl_pkg SHALL hold the state enum, opcode constants (LW, SW, RTYPE, BEQ, ADDI, J), funct constants and the aluop type.
REQ-035 ALU decoding SHALL live in a combinational sub-module aludec (aluop, funct -> alucontrol); the main FSM and output decode SHALL be in multicycle_controller.

Verification
REQ-036 Reset 2 cycles, op=001000 (addi $v0,$zero,7) -> states 0,1,9,10,0; regwrite=1 only in state 10, regdst=0.
REQ-037 op=101011 (sw to 0x44) -> states 0,1,2,5,0; memwrite=1 and iord=1 only in state 5.
REQ-038 op=000000, funct=100000 (add) -> alucontrol=010 in EXECUTE, regdst=1 and regwrite=1 in ALUWB; funct=101010 -> alucontrol=111.
REQ-039 op=000100 with zero=1 -> pcen=1, pcsrc=01 in BRANCH; with zero=0 -> pcen=0 in BRANCH.
REQ-040 op=100011 (lw) then reset asserted in MEMRD -> state=FETCH next edge, no regwrite pulse; op=111111 -> DECODE->FETCH, no writes.
